// File: rtl/mant_div_seq.sv
// Sequential restoring mantissa divider: one quotient bit per clock, WIDTH+1 quotient bits.
// Optional remainder-nonzero output o_sticky is built only when MANT_DIV_STICKY_EN is defined.
module mant_div_seq #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH:0]   o_quotient,
    output logic             o_err
`ifdef MANT_DIV_STICKY_EN
    ,
    output logic             o_sticky
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] qsr_q, qsr_d;
    logic             valid_q, valid_d;
    logic [WIDTH:0]   quot_q, quot_d;
    logic             err_q, err_d;
`ifdef MANT_DIV_STICKY_EN
    logic             sticky_q, sticky_d;
`endif

    logic [WIDTH+1:0] sum;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;

    // Trial subtract R - B as R + ~{0,B} + 1; the carry-out means R >= B.
    assign sum      = {1'b0, rem_q} + {1'b0, ~{1'b0, div_q}} + {{(WIDTH + 1){1'b0}}, 1'b1};
    assign q_bit    = sum[WIDTH+1];
    assign rem_next = q_bit ? sum[WIDTH:0] : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        div_d    = div_q;
        qsr_d    = qsr_q;
        valid_d  = 1'b0;
        quot_d   = quot_q;
        err_d    = err_q;
`ifdef MANT_DIV_STICKY_EN
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (i_divisor[WIDTH-1]) begin
                        div_d   = i_divisor;
                        rem_d   = {1'b0, i_dividend};
                        qsr_d   = '0;
                        cnt_d   = CntW'(WIDTH);
                        state_d = StRun;
                    end else begin
                        // Unnormalized divisor (including zero): immediate error result.
                        valid_d  = 1'b1;
                        err_d    = 1'b1;
                        quot_d   = '1;
`ifdef MANT_DIV_STICKY_EN
                        sticky_d = 1'b0;
`endif
                    end
                end
            end
            StRun: begin
                qsr_d = {qsr_q[WIDTH-2:0], q_bit};
                if (cnt_q != '0) begin
                    rem_d = rem_next << 1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    valid_d  = 1'b1;
                    err_d    = 1'b0;
                    quot_d   = {qsr_q, q_bit};
`ifdef MANT_DIV_STICKY_EN
                    sticky_d = |rem_next;
`endif
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            qsr_q    <= '0;
            valid_q  <= 1'b0;
            quot_q   <= '0;
            err_q    <= 1'b0;
`ifdef MANT_DIV_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            qsr_q    <= qsr_d;
            valid_q  <= valid_d;
            quot_q   <= quot_d;
            err_q    <= err_d;
`ifdef MANT_DIV_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign o_busy     = (state_q == StRun);
    assign o_valid    = valid_q;
    assign o_quotient = quot_q;
    assign o_err      = err_q;
`ifdef MANT_DIV_STICKY_EN
    assign o_sticky   = sticky_q;
`endif

endmodule

// File: tb/tb_mant_div_seq.sv
// Directed self-checking bench for mant_div_seq (WIDTH=24); sticky checks follow MANT_DIV_STICKY_EN.
module tb_mant_div_seq;

    localparam int unsigned WIDTH = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             valid;
    logic [WIDTH:0]   quotient;
    logic             err;
`ifdef MANT_DIV_STICKY_EN
    logic             sticky;
`endif

    int pass_cnt = 0;
    int total    = 0;

    mant_div_seq #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_quotient (quotient),
        .o_err      (err)
`ifdef MANT_DIV_STICKY_EN
        ,
        .o_sticky   (sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_sticky(input string tag, input logic exp);
`ifdef MANT_DIV_STICKY_EN
        check(tag, {63'd0, sticky}, {63'd0, exp});
`endif
    endtask

    // Count edges from the accepting edge until o_valid, bounded.
    task automatic wait_valid(input int from, output int lat);
        lat = from;
        while (!valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH:0] exp_q, input logic exp_s);
        int lat;
        accept(a, b);
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        wait_valid(0, lat);
        check({tag, "_lat"}, 64'(lat), 64'd25);
        check({tag, "_q"}, 64'(quotient), 64'(exp_q));
        check({tag, "_err"}, {63'd0, err}, 64'd0);
        check_sticky({tag, "_sticky"}, exp_s);
        tick();
        check({tag, "_vpulse"}, {63'd0, valid}, 64'd0);
    endtask

    initial begin
        int            lat;
        logic [63:0]   num;
        logic [63:0]   mq;
        logic          ms;
        bit            saw_valid;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check_sticky("rst_sticky", 1'b0);

        run_op("d15_10", 24'hC00000, 24'h800000, 25'h1800000, 1'b0);
        run_op("d10_15", 24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b1);
        run_op("dmax", 24'hFFFFFF, 24'h800000, 25'h1FFFFFE, 1'b0);
        run_op("dzero", 24'h000000, 24'h800000, 25'h0000000, 1'b0);

        num = {16'd0, 24'h123456, 24'd0};
        mq  = num / 64'h0000_0000_00FE_DCBA;
        ms  = (num % 64'h0000_0000_00FE_DCBA) != 0;
        run_op("dmix", 24'h123456, 24'hFEDCBA, mq[WIDTH:0], ms);

        // Unnormalized divisors take the one-cycle error path.
        accept(24'h123456, 24'h000000);
        check("e0_valid", {63'd0, valid}, 64'd1);
        check("e0_err", {63'd0, err}, 64'd1);
        check("e0_q", 64'(quotient), 64'h1FFFFFF);
        check("e0_busy", {63'd0, busy}, 64'd0);
        check_sticky("e0_sticky", 1'b0);
        tick();
        check("e0_vpulse", {63'd0, valid}, 64'd0);
        check("e0_hold", 64'(quotient), 64'h1FFFFFF);
        accept(24'hFFFFFF, 24'h7FFFFF);
        check("e7f_valid", {63'd0, valid}, 64'd1);
        check("e7f_err", {63'd0, err}, 64'd1);
        check("e7f_busy", {63'd0, busy}, 64'd0);
        tick();

        // Start pulse mid-run is ignored; start in the valid cycle is accepted.
        accept(24'hC00000, 24'h800000);
        for (int i = 0; i < 9; i++) tick();
        dividend = 24'h800000;
        divisor  = 24'hC00000;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_valid(10, lat);
        check("ign_lat", 64'(lat), 64'd25);
        check("ign_q", 64'(quotient), 64'h1800000);
        accept(24'h800000, 24'hC00000);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_valid(0, lat);
        check("b2b_lat", 64'(lat), 64'd25);
        check("b2b_q", 64'(quotient), 64'h0AAAAAA);
        tick();

        // Reset mid-run aborts without a result strobe.
        accept(24'hFFFFFF, 24'h800000);
        for (int i = 0; i < 11; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, valid}, 64'd0);
        check("abort_q", 64'(quotient), 64'd0);
        check("abort_err", {63'd0, err}, 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid) saw_valid = 1'b1;
        end
        check("abort_noval", {63'd0, saw_valid}, 64'd0);
        run_op("post", 24'hC00000, 24'h800000, 25'h1800000, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mant_div_seq.md
# mant_div_seq

Sequential restoring divider for normalized floating-point mantissas; the division counterpart of the mantissa multiply path. Accepts a dividend/divisor pair through a start/busy handshake, produces one quotient bit per clock, and returns a WIDTH+1-bit quotient plus remainder status for the exponent/rounding stage of the FP divide datapath.

## Interface

- WIDTH, 24, mantissa width including hidden bit
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset; one clock; reset is synchronous and active-high
- i_start  input  1  request; sampled only in IDLE
- i_dividend  input  WIDTH  dividend mantissa (any value)
- i_divisor  input  WIDTH  divisor mantissa; MSB must be 1
- o_busy  output  1  high while in RUN
- o_valid  output  1  one-cycle result strobe
- o_quotient  output  WIDTH+1  floor(i_dividend * 2^WIDTH / i_divisor)
- o_err  output  1  divisor not normalized (includes zero); qualified by o_valid
- o_sticky  output  1  remainder nonzero; present only with MANT_DIV_STICKY_EN

## Operation

- States: IDLE, RUN.
- IDLE & i_start & i_divisor[WIDTH-1]=1: capture divisor B; remainder R (WIDTH+1 bits) <= {0, i_dividend}; quotient shift register cleared; counter <= WIDTH; go RUN.
- IDLE & i_start & i_divisor[WIDTH-1]=0: stay IDLE; next cycle o_valid=1, o_err=1, o_quotient=all ones, o_sticky=0.
- RUN, each cycle: trial difference D = R + ~{0,B} + 1 (WIDTH+1-bit ripple add, carry-in 1). Carry-out 1 (R >= B): quotient bit 1, R <= D; else bit 0, R unchanged. Bit shifted into quotient LSB. If counter != 0: R <= R_next << 1, counter decrements. If counter == 0: load o_quotient, o_sticky, assert o_valid, o_err=0, go IDLE.
- Invariant: R < 2B every iteration (B normalized, dividend < 2^WIDTH); R needs no more than WIDTH+1 bits, no overflow.
- o_quotient/o_err/o_sticky hold last result until next o_valid.
- i_start in RUN ignored; operands not re-sampled.
- i_dividend/i_divisor only sampled at the accepting edge; may change afterwards.

## Timing

- Reset: state IDLE, o_busy=0, o_valid=0, o_quotient=0, o_err=0, o_sticky=0, counter=0, R=0.
- Start accepted at edge k: o_busy=1 from k to k+WIDTH (WIDTH+1 cycles); at edge k+WIDTH+1 o_busy=0, o_valid=1 for exactly one cycle.
- Latency: WIDTH+1 cycles start-to-valid (25 at default); error path 1 cycle.
- Back-to-back: i_start asserted in the o_valid cycle is accepted (state already IDLE); throughput one result per WIDTH+1 cycles.
- i_rst during RUN: abort at that edge, all outputs to reset values, no o_valid for the aborted op; i_rst dominates i_start.

## Configuration

- MANT_DIV_STICKY_EN defined: o_sticky port exists, = OR-reduce of final remainder, registered with o_quotient.
- Not defined: o_sticky port and its logic absent; quotient is truncated; all other behaviour and timing identical.

## Test plan

- WIDTH=24, dividend 0xC00000, divisor 0x800000 (1.5/1.0) -> o_valid 25 cycles after start, o_quotient 0x1800000, o_err 0, o_sticky 0.
- Dividend 0x800000, divisor 0xC00000 (1.0/1.5) -> o_quotient 0x0AAAAAA, o_sticky 1.
- Dividend 0xFFFFFF, divisor 0x800000 -> o_quotient 0x1FFFFFE, o_sticky 0; dividend 0x000000 -> o_quotient 0.
- Divisor 0x000000 or 0x7FFFFF -> o_valid next cycle, o_err 1, o_quotient 0x1FFFFFF, o_busy never high.
- Pulse i_start with new operands at cycle 10 of a RUN -> ignored, first result unchanged; i_start in o_valid cycle -> second op accepted, second o_valid 25 cycles later.
- i_rst at cycle 12 of RUN -> next cycle all outputs 0, no o_valid; fresh start afterwards returns correct result.
